// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-outstanding RV32I load/store unit between a CPU request/response
//   port and a word-oriented memory port. Each request is checked for
//   funct3 legality and alignment. Stores are replicated across the word
//   with byte enables. Loads fetch the aligned word, then extract and extend
//   the addressed byte or halfword.
//
//   Build option: define LSU_TIMEOUT_EN to bound the read-response wait to
//   TIMEOUT_CYCLES cycles. On expiry the unit returns resp_error=1. Without
//   the macro the unit waits indefinitely.
//
//   Parameters
//     TIMEOUT_CYCLES  read-response wait limit in cycles (min 2, default 16)
//   Ports
//     clk, reset                  clock; asynchronous active-high reset
//     req_valid/req_ready         CPU request handshake (ready only in IDLE)
//     req_write, req_funct3       1=store; RV32I load/store funct3
//     req_addr, req_wdata         byte address; store data
//     resp_valid                  one-cycle registered response strobe
//     resp_rdata, resp_error      extended load data; error flag
//     mem_req_valid/mem_req_ready memory request handshake
//     mem_write, mem_addr         store flag; word-aligned address
//     mem_wdata, mem_byte_en      formatted store data; byte enables
//     mem_rsp_valid, mem_rdata    read response strobe; full aligned word
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state;
  logic        cap_write;
  logic [2:0]  cap_funct3;
  logic [1:0]  cap_offset;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_byte_en_q;
  logic        resp_valid_q;
  logic        resp_error_q;
  logic [31:0] resp_rdata_q;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
`endif

  // Request decode
  logic        funct3_legal;
  logic        misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_byte_en;

  always_comb begin
    funct3_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
      3'b100, 3'b101:         funct3_legal = ~req_write;
      default:                funct3_legal = 1'b0;
    endcase
    // funct3[1:0] gives the access size for every legal encoding
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    st_wdata   = req_wdata;
    st_byte_en = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        st_wdata   = {4{req_wdata[7:0]}};
        st_byte_en = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_wdata   = {2{req_wdata[15:0]}};
        st_byte_en = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata   = req_wdata;
        st_byte_en = 4'b1111;
      end
    endcase
  end

  // Load extraction from the returned word
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = mem_rdata[{cap_offset, 3'b000} +: 8];
    ld_half = cap_offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (cap_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cap_write     <= 1'b0;
      cap_funct3    <= '0;
      cap_offset    <= '0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_byte_en_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_rdata_q  <= '0;
`ifdef LSU_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // req_ready is high throughout IDLE outside reset
          if (req_valid) begin
            cap_write  <= req_write;
            cap_funct3 <= req_funct3;
            cap_offset <= req_addr[1:0];
            if (funct3_legal && !misaligned) begin
              state         <= ISSUE;
              mem_write_q   <= req_write;
              mem_addr_q    <= {req_addr[31:2], 2'b00};
              mem_wdata_q   <= req_write ? st_wdata : '0;
              mem_byte_en_q <= req_write ? st_byte_en : 4'b1111;
            end else begin
              state        <= DONE;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= '0;
            end
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            if (cap_write) begin
              state        <= DONE;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b0;
              resp_rdata_q <= '0;
            end else begin
              state <= WAIT_RSP;
`ifdef LSU_TIMEOUT_EN
              to_cnt <= '0;
`endif
            end
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            state        <= DONE;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
            resp_rdata_q <= ld_data;
          end
`ifdef LSU_TIMEOUT_EN
          // to_cnt counts completed WAIT_RSP cycles; a response in the
          // final cycle takes priority over expiry
          else if (to_cnt == TO_LAST) begin
            state        <= DONE;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state == IDLE) & ~reset;
  assign resp_valid    = resp_valid_q;
  assign resp_error    = resp_error_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_req_valid = (state == ISSUE);
  assign mem_write     = mem_write_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_byte_en   = mem_byte_en_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit. Each vector carries hand-computed
//   response values. An arithmetic model predicts memory-side fields and
//   timing. A negedge compare process checks every output on every cycle.
module tb_load_store_unit;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_error    (resp_error),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_byte_en   (mem_byte_en),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Expectations for the transaction in flight (cycle numbers use cyc)
  logic        chk_en = 1'b0;
  logic        act    = 1'b0;
  int          exp_n, exp_r, exp_iss_end;
  logic        exp_legal;
  logic        exp_mw;
  logic [31:0] exp_maddr, exp_mwdata, exp_rdata;
  logic [3:0]  exp_be;
  logic        exp_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic model_legal(input logic w, input logic [2:0] f3, input logic [31:0] a);
    int unsigned size;
    logic ok;
    if (w) ok = (f3 <= 3'd2);
    else   ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size = (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 1;
    return ok && ((a % size) == 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    int unsigned off;
    logic [31:0] v;
    off = a % 4;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (word >> (8 * off)) & 32'hFF;
      if (f3 == 3'd0 && v >= 128) v = v - 256;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (word >> (16 * (off / 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32768) v = v - 65536;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store_data(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned off;
    off = a % 4;
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (act) begin
        chk("req_ready", req_ready, (cyc >= exp_n && cyc <= exp_r) ? 0 : 1);
        chk("resp_valid", resp_valid, (cyc == exp_r) ? 1 : 0);
        if (cyc == exp_r) begin
          chk("resp_rdata", resp_rdata, exp_rdata);
          chk("resp_error", resp_error, exp_err);
        end
        chk("mem_req_valid", mem_req_valid,
            (exp_legal && cyc >= exp_n && cyc <= exp_iss_end) ? 1 : 0);
        if (exp_legal && cyc >= exp_n && cyc <= exp_iss_end) begin
          chk("mem_write", mem_write, exp_mw);
          chk("mem_addr", mem_addr, exp_maddr);
          chk("mem_wdata", mem_wdata, exp_mwdata);
          chk("mem_byte_en", mem_byte_en, exp_be);
        end
      end else begin
        chk("idle_req_ready", req_ready, 1);
        chk("idle_resp_valid", resp_valid, 0);
        chk("idle_mem_req_valid", mem_req_valid, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] word,
                     input int rd, input int sd, input bit no_rsp, input bit bogus,
                     input logic [31:0] hand_rdata, input logic hand_err);
    int c, n;
    logic legal;
    legal = model_legal(w, f3, a);
    exp_legal  = legal;
    exp_err    = !legal || (no_rsp && !w);
    exp_rdata  = (!legal || w || no_rsp) ? 32'h0 : model_load(f3, a, word);
    chk("model_rdata", exp_rdata, hand_rdata);
    chk("model_error", exp_err, hand_err);
    exp_mw     = w;
    exp_maddr  = a & ~32'h3;
    exp_mwdata = w ? model_store_data(f3, d) : 32'h0;
    exp_be     = w ? model_be(f3, a) : 4'hF;
    c = cyc;
    n = c + 1;
    exp_n       = n;
    exp_iss_end = n + rd;
    exp_r = !legal ? n : w ? n + 1 + rd : no_rsp ? n + 1 + rd + TO : n + 2 + rd + sd;
    act = 1'b1;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = $urandom;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #2;
      c = cyc;
      req_valid = 1'b0; req_write = $urandom_range(0, 1); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      mem_req_ready = (c >= n + rd);
      mem_rsp_valid = 1'b0;
      mem_rdata = $urandom;
      if (!w && legal && !no_rsp && c == n + 1 + rd + sd) begin
        mem_rsp_valid = 1'b1;
        mem_rdata = word;
      end else if (bogus && c <= n + rd) begin
        mem_rsp_valid = 1'b1;
      end
      if (c > exp_r) break;
    end
    act = 1'b0;
  endtask

  task automatic check_reset_values(input logic want_ready);
    chk("rst_req_ready", req_ready, want_ready);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_error", resp_error, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_byte_en", mem_byte_en, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    #1;
    check_reset_values(1'b0);

    // Pin the model against hand-worked values
    chk("pin_lb", model_load(3'd0, 32'h103, 32'h80FF_FF11), 32'hFFFF_FF80);
    chk("pin_lhu", model_load(3'd5, 32'h102, 32'h80FF_FF11), 32'h0000_80FF);
    chk("pin_sh_data", model_store_data(3'd1, 32'h1234_ABCD), 32'hABCD_ABCD);
    chk("pin_sh_be", model_be(3'd1, 32'h22), 4'b1100);
    chk("pin_sb_be", model_be(3'd0, 32'h301), 4'b0010);

    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values(1'b1);
    @(posedge clk); #2;
    chk_en = 1'b1;

    //   w     f3     addr        wdata         mem word      rd sd nr bg  rdata         err
    run(1'b0, 3'd0, 32'h103, 32'h0,         32'h80FF_FF11, 0, 0, 0, 0, 32'hFFFF_FF80, 1'b0);
    run(1'b1, 3'd1, 32'h22,  32'h1234_ABCD, 32'h0,         3, 0, 0, 0, 32'h0,         1'b0);
    run(1'b0, 3'd2, 32'h41,  32'h0,         32'h0,         0, 0, 0, 0, 32'h0,         1'b1);
    run(1'b0, 3'd3, 32'h40,  32'h0,         32'h0,         0, 0, 0, 0, 32'h0,         1'b1);
    run(1'b0, 3'd4, 32'h102, 32'h0,         32'h80FF_FF11, 0, 0, 0, 0, 32'h0000_00FF, 1'b0);
    run(1'b0, 3'd1, 32'h102, 32'h0,         32'h80FF_FF11, 1, 1, 0, 0, 32'hFFFF_80FF, 1'b0);
    run(1'b0, 3'd5, 32'h100, 32'h0,         32'h80FF_FF11, 0, 2, 0, 0, 32'h0000_FF11, 1'b0);
    run(1'b0, 3'd1, 32'h100, 32'h0,         32'h0001_7FFF, 0, 0, 0, 0, 32'h0000_7FFF, 1'b0);
    run(1'b0, 3'd2, 32'h200, 32'h0,         32'hDEAD_BEEF, 2, 3, 0, 1, 32'hDEAD_BEEF, 1'b0);
    run(1'b1, 3'd0, 32'h301, 32'h0000_00A5, 32'h0,         0, 0, 0, 0, 32'h0,         1'b0);
    run(1'b1, 3'd2, 32'h304, 32'hCAFE_F00D, 32'h0,         1, 0, 0, 0, 32'h0,         1'b0);
    run(1'b1, 3'd1, 32'h21,  32'h5555_5555, 32'h0,         0, 0, 0, 0, 32'h0,         1'b1);
    run(1'b1, 3'd4, 32'h20,  32'h5555_5555, 32'h0,         0, 0, 0, 0, 32'h0,         1'b1);
    run(1'b0, 3'd5, 32'h101, 32'h0,         32'h0,         0, 0, 0, 0, 32'h0,         1'b1);
    run(1'b0, 3'd7, 32'h100, 32'h0,         32'h0,         0, 0, 0, 0, 32'h0,         1'b1);
    run(1'b0, 3'd0, 32'h000, 32'h0,         32'h0000_007F, 2, 0, 0, 1, 32'h0000_007F, 1'b0);
    run(1'b0, 3'd0, 32'h101, 32'h0,         32'h0000_8000, 0, 1, 0, 0, 32'hFFFF_FF80, 1'b0);
    run(1'b0, 3'd5, 32'h52,  32'h0,         32'h1234_8001, 0, TO - 1, 0, 0, 32'h0000_1234, 1'b0);
`ifdef LSU_TIMEOUT_EN
    run(1'b0, 3'd5, 32'h52,  32'h0,         32'h1234_8001, 0, 0, 1, 0, 32'h0,         1'b1);
`else
    run(1'b0, 3'd2, 32'h60,  32'h0,         32'h0BAD_F00D, 0, 40, 0, 0, 32'h0BAD_F00D, 1'b0);
`endif

    // Reset while waiting for a read response, then a late response
    chk_en = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h80;
    mem_req_ready = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_reset_values(1'b0);
    @(posedge clk); #2;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1357_9BDF;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_reset_values(1'b1);
    end
    @(posedge clk); #2;
    mem_rsp_valid = 1'b0;
    chk_en = 1'b1;

    // A normal transaction still works after the abandoned one
    run(1'b0, 3'd2, 32'h84, 32'h0, 32'h2468_ACE0, 0, 0, 0, 0, 32'h2468_ACE0, 1'b0);
    @(posedge clk); #2;
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning read-response wait limit in cycles (min 2).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have CPU request ports: req_valid in 1; req_ready out 1; req_write in 1 (1=store); req_funct3 in 3 (RV32I load/store funct3); req_addr in 32 (byte address); req_wdata in 32 (store data).
REQ-005 SHALL have CPU response ports: resp_valid out 1; resp_rdata out 32 (extended load data); resp_error out 1 (misaligned, illegal funct3 or timeout).
REQ-006 SHALL have memory request ports: mem_req_valid out 1; mem_req_ready in 1; mem_write out 1; mem_addr out 32 (word address: byte address with [1:0]=0); mem_wdata out 32; mem_byte_en out 4.
REQ-007 SHALL have memory response ports: mem_rsp_valid in 1; mem_rdata in 32 (full aligned word).

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT_RSP, DONE.
REQ-009 SHALL assert req_ready only in IDLE; request accepted when req_valid && req_ready; all request fields captured on accept.
REQ-010 On accept of legal aligned request SHALL go to ISSUE; illegal or misaligned request SHALL go directly to DONE with resp_error=1, resp_rdata=0, no memory access.
REQ-011 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all others illegal.
REQ-012 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-013 In ISSUE SHALL hold mem_req_valid=1 with stable mem_write/mem_addr/mem_wdata/mem_byte_en until mem_req_ready=1; on handshake store goes to DONE, load goes to WAIT_RSP.
REQ-014 Store formatting: SB wdata={4{wdata[7:0]}}, byte_en=4'b0001<<addr[1:0]; SH wdata={2{wdata[15:0]}}, byte_en=addr[1]?1100:0011; SW wdata unchanged, byte_en=1111.
REQ-015 Loads SHALL drive mem_byte_en=1111, mem_wdata=0.
REQ-016 In WAIT_RSP SHALL capture mem_rdata when mem_rsp_valid=1 and go to DONE; mem_rsp_valid in any other state SHALL be ignored.
REQ-017 Load extraction: byte = mem_rdata[8*addr[1:0]+:8], halfword = mem_rdata[16*addr[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-018 In DONE SHALL assert resp_valid for exactly one cycle, then return to IDLE; no backpressure on response; stores return resp_rdata=0.
REQ-019 Minimum latency accept->resp_valid: store with mem_req_ready high = 2 cycles; load with ready high and response next cycle = 3 cycles; illegal = 1 cycle.
REQ-020 Outputs resp_valid, resp_error, resp_rdata SHALL be registered; mem_* outputs SHALL be driven from registered state only.

Reset
REQ-021 Reset SHALL force IDLE, clear timeout counter and captured fields at any point, including mid-transaction; pending memory transaction is abandoned.
REQ-022 Reset values: req_ready=0 during reset then 1 in IDLE; resp_valid=0; resp_error=0; resp_rdata=0; mem_req_valid=0; mem_write=0; mem_addr=0; mem_wdata=0; mem_byte_en=0.

Configuration
REQ-023 Macro LSU_TIMEOUT_EN defined: counter clears on entering WAIT_RSP, increments each WAIT_RSP cycle; reaching TIMEOUT_CYCLES without mem_rsp_valid goes to DONE with resp_error=1, resp_rdata=0; mem_rsp_valid in the expiry cycle wins (normal response).
REQ-024 Macro LSU_TIMEOUT_EN undefined: no counter; WAIT_RSP waits indefinitely; resp_error set only by REQ-010.

Verification
REQ-025 LB addr=0x103, mem_rdata=0x80FF_FF11 -> mem_addr=0x100, byte_en=1111, resp_rdata=0xFFFF_FF80, resp_error=0.
REQ-026 SH addr=0x22, wdata=0x1234_ABCD, mem_req_ready low 3 cycles -> mem_req_valid held 4 cycles stable, mem_addr=0x20, wdata=0xABCD_ABCD, byte_en=1100, then single resp_valid, rdata=0.
REQ-027 LW addr=0x41 -> no mem_req_valid, resp_valid 1 cycle after accept with resp_error=1, rdata=0; same for funct3=011.
REQ-028 With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, LHU with no mem_rsp_valid -> resp_error=1 after 16 WAIT_RSP cycles; response on 16th cycle -> resp_error=0, correct data.
REQ-029 Reset asserted during WAIT_RSP, then late mem_rsp_valid=1 -> all outputs at reset values, no resp_valid, req_ready=1 after reset release.
